pwm_multi_channel: RTL and testbench
====================================

Name: pwm_multi_channel

Overview:
- Multi-channel PWM generator for the filter/actuator output stage.
- All CHANNELS outputs share one period counter with a programmable period and edge- or center-aligned counting.
- Each channel has a double-buffered duty register, so duty changes apply only at a period boundary and outputs never glitch mid-period.
- A period_start strobe synchronises downstream sampling logic.

Parameters:
WIDTH, 8, bit width of counter, period and duty values
CHANNELS, 4, number of independent PWM outputs (>=1)

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
enable  input  1  run counter; low holds block in reload state with outputs low
period_val  input  WIDTH  period setting P, sampled only at reload
center_mode  input  1  0=edge-aligned, 1=center-aligned, sampled only at reload
duty_in  input  CHANNELS*WIDTH  duty values, channel ch at bits [ch*WIDTH +: WIDTH]
duty_wr  input  CHANNELS  per-channel write strobe into duty shadow
pwm_out  output  CHANNELS  registered PWM outputs
period_start  output  1  one-cycle strobe aligned with first output cycle of each period

Behaviour:
- Reset (async): cnt=0, dir=up, duty shadows=0, active duty=0, period_act=0, mode_act=0, pwm_out=0, period_start=0.
- Shadow write:
  - duty_wr[ch]=1 at a clock edge writes duty_in slice ch into shadow ch.
  - Accepted in any cycle, including while enable=0.
- Reload event: loads period_act<=period_val, mode_act<=center_mode, active duty[ch]<=shadow[ch], cnt<=0, dir<=up.
  - Simultaneous write: if duty_wr[ch]=1 in the reload cycle, active duty[ch] takes duty_in directly (bypass), and the shadow is also updated.
- Reload occurs:
  - (a) every cycle with enable=0;
  - (b) at the period boundary while enabled.
- Edge mode (mode_act=0):
  - cnt counts 0..period_act; period = period_act+1 cycles.
  - Boundary = cycle with cnt==period_act.
- Center mode (mode_act=1, period_act>=1):
  - Sequence per period: 0,1,..,P-1 with dir=up, then P-1,..,1,0 with dir=down; period = 2P cycles.
  - At dir=up and cnt==P-1: dir<=down, cnt holds.
  - Boundary = cycle with dir=down and cnt==0.
  - P=1 gives the sequence 0,0.
- Center mode with period_act=0: every cycle is a boundary, cnt stays 0.
- Outputs, each enabled cycle:
  - pwm_out[ch] <= (cnt < active duty[ch]), unsigned compare.
  - pwm_out lags cnt by one cycle.
  - Duty 0 gives constant low.
  - Edge duty >= P+1 gives constant high; edge high time = min(d,P+1) cycles.
  - Center high time = 2*min(d,P) cycles, symmetric about period middle.
- period_start <= enable & (cnt==0) & (mode_act==0 | dir==up); it coincides with the pwm_out cycle of the first count of each period.
- enable=0:
  - pwm_out<=0 and period_start<=0 on the next edge; counter continuously reloads.
  - On enable rising, the first enabled cycle counts from cnt=0 using the freshest shadow/period/mode.
- period_val or center_mode changes mid-period have no effect until the next reload.
- Widths: cnt and comparisons are WIDTH bits; P=2^WIDTH-1 is legal in both modes with no overflow.
- Reset mid-operation returns all state to reset values immediately; shadows are lost.

Test Plan:
- Edge, P=9, d0=3, d1=0, d2=10, d3=255, enable high -> per 10-cycle period ch0 high 3 cycles then low 7, ch1 always low, ch2/ch3 always high; period_start every 10 cycles, coincident with ch0 rising edge.
- Center, P=4, d0=2 -> repeating 8-cycle pwm_out[0] pattern H,H,L,L,L,L,H,H; period_start every 8 cycles on the first H.
- Edge P=9, d0=3: write d0=7 at cycle 4 of a period -> current period stays 3 high, next period 7 high. Repeat with duty_wr asserted exactly in the boundary cycle (cnt==9) -> next period already 7 high (bypass).
- Change period_val 9->4 and center_mode 0->1 mid-period -> current edge period completes 10 cycles, then 8-cycle center periods start.
- Drop enable for 3 cycles mid-period -> pwm_out and period_start low from next edge. On re-enable, period_start fires on the first output cycle and the full period restarts from cnt=0, with shadow writes made during disable applied.
- Assert reset mid-period with d0=5 -> pwm_out=0 and period_start=0 immediately. After release with enable high, all outputs stay low until new duties are written and a boundary passes.

Source files
------------

// File: rtl/pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// pwm_multi_channel
//
// Multi-channel PWM generator for the filter/actuator output stage. All
// channels share one period counter. The period length and the counting style
// (edge- or center-aligned) are taken from the inputs only at a reload. Each
// channel has a shadow duty register that software may write at any time. The
// active duty register picks up the shadow value only at a reload, so an
// output never changes its duty in the middle of a period.
//
// A reload happens in every cycle with enable low, and at the period boundary
// while enabled. While disabled, the block therefore sits in its reload state
// with cnt=0. The first enabled cycle then counts from 0 using the newest
// shadow, period and mode values.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   enable        run the counter; low holds the reload state with outputs low
//   period_val    period setting P (WIDTH bits), sampled only at reload
//   center_mode   0 = edge-aligned, 1 = center-aligned, sampled only at reload
//   duty_in       packed duty values, channel ch at [ch*WIDTH +: WIDTH]
//   duty_wr       per-channel write strobe into the duty shadow registers
//   pwm_out       registered PWM outputs, one per channel
//   period_start  one-cycle strobe on the first output cycle of each period
// -----------------------------------------------------------------------------
module pwm_multi_channel #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [WIDTH-1:0]          period_val,
    input  logic                      center_mode,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic [CHANNELS-1:0]       duty_wr,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    // Shared counter state and the period/mode captured at the last reload.
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    dir_e             dir_q,    dir_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q,   mode_d;

    // Per-channel shadow (software-visible) and active (compared) duties.
    logic [WIDTH-1:0] shadow_q [CHANNELS];
    logic [WIDTH-1:0] shadow_d [CHANNELS];
    logic [WIDTH-1:0] duty_q   [CHANNELS];
    logic [WIDTH-1:0] duty_d   [CHANNELS];

    logic [CHANNELS-1:0] pwm_q,    pwm_d;
    logic                pstart_q, pstart_d;

    logic boundary;
    logic reload;

    // -------------------------------------------------------------------------
    // Period boundary and reload detection
    // -------------------------------------------------------------------------
    // In edge mode the last count of a period is cnt==P. In center mode the
    // counter goes up to P-1, holds one cycle while it turns, and then comes
    // back down. The last count is therefore cnt==0 on the way down. When the
    // period is zero in center mode, the up and down halves are both empty,
    // so every cycle is a boundary.
    always_comb begin
        // NOTE: every signal driven here gets a default value before any
        // branch. A path that leaves a signal unassigned would infer a latch.
        boundary = 1'b0;
        if (!mode_q) begin
            boundary = (cnt_q == period_q);
        end else if (period_q == CNT_ZERO) begin
            boundary = 1'b1;
        end else begin
            boundary = (dir_q == DIR_DOWN) && (cnt_q == CNT_ZERO);
        end
        reload = !enable || boundary;
    end

    // -------------------------------------------------------------------------
    // Counter next state
    // -------------------------------------------------------------------------
    // The counter never goes above period_q in edge mode and never goes above
    // period_q-1 in center mode. This holds even for P = 2^WIDTH-1, so the
    // WIDTH-bit counter cannot wrap.
    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        period_d = period_q;
        mode_d   = mode_q;
        if (reload) begin
            cnt_d    = CNT_ZERO;
            dir_d    = DIR_UP;
            period_d = period_val;
            mode_d   = center_mode;
        end else if (!mode_q) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (dir_q == DIR_UP) begin
            // At the top of the up-count, turn around and repeat the same
            // count once. This makes the waveform symmetric about the middle
            // of the period.
            if (cnt_q == period_q - CNT_ONE) begin
                dir_d = DIR_DOWN;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Duty registers
    // -------------------------------------------------------------------------
    // A write in the reload cycle goes straight to the active register as well
    // as to the shadow. This lets a write that arrives exactly at the boundary
    // take effect in the very next period.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            shadow_d[ch] = shadow_q[ch];
            duty_d[ch]   = duty_q[ch];
            if (duty_wr[ch]) begin
                shadow_d[ch] = duty_in[ch*WIDTH +: WIDTH];
            end
            if (reload) begin
                duty_d[ch] = duty_wr[ch] ? duty_in[ch*WIDTH +: WIDTH] : shadow_q[ch];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output next state
    // -------------------------------------------------------------------------
    // Outputs are computed from the current count and the current active duty,
    // so pwm_out lags cnt by one cycle. period_start marks the cycle whose
    // count is the first count of a period. In center mode that count is
    // cnt==0 on the way up only.
    always_comb begin
        pwm_d = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            pwm_d[ch] = enable && (cnt_q < duty_q[ch]);
        end
        pstart_d = enable && (cnt_q == CNT_ZERO) && (!mode_q || (dir_q == DIR_UP));
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= CNT_ZERO;
            dir_q    <= DIR_UP;
            period_q <= CNT_ZERO;
            mode_q   <= 1'b0;
            pwm_q    <= '0;
            pstart_q <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments. All registers
            // then update together from the values present before the edge,
            // whatever order the statements are written in.
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            pwm_q    <= pwm_d;
            pstart_q <= pstart_d;
        end
    end

    // NOTE: the duty arrays are reset on purpose. After a reset the outputs
    // must stay low until software writes new duties, so neither the shadow
    // nor the active copy may keep a stale value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                shadow_q[ch] <= CNT_ZERO;
                duty_q[ch]   <= CNT_ZERO;
            end
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                shadow_q[ch] <= shadow_d[ch];
                duty_q[ch]   <= duty_d[ch];
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = pstart_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_channel
//
// Directed bench for pwm_multi_channel. It uses a reference model that tracks
// the position k inside the current period and the period length. The count
// is derived from k: k itself in edge mode; in center mode, k on the way up
// and 2P-1-k on the way down. Before each clock edge, the model's expected
// outputs are pushed to a scoreboard queue. After the edge, they are popped
// and compared against the DUT.
// -----------------------------------------------------------------------------
module tb_pwm_multi_channel;

    localparam int WIDTH = 8;
    localparam int CH    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [WIDTH-1:0]  period_val;
    logic              center_mode;
    logic [CH*WIDTH-1:0] duty_in;
    logic [CH-1:0]     duty_wr;
    logic [CH-1:0]     pwm_out;
    logic              period_start;

    pwm_multi_channel #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .period_val   (period_val),
        .center_mode  (center_mode),
        .duty_in      (duty_in),
        .duty_wr      (duty_wr),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH-1:0] pwm;
        logic          ps;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state.
    int m_k;
    int m_p;
    int m_mode;
    int m_duty   [CH];
    int m_shadow [CH];

    logic [CH-1:0] last_pwm;
    logic          last_ps;

    function automatic int model_len();
        if (m_mode == 0) return m_p + 1;
        if (m_p == 0)    return 1;
        return 2 * m_p;
    endfunction

    function automatic int model_cnt();
        if (m_mode == 0) return m_k;
        if (m_p == 0)    return 0;
        return (m_k < m_p) ? m_k : (2 * m_p - 1 - m_k);
    endfunction

    task automatic model_reset();
        m_k    = 0;
        m_p    = 0;
        m_mode = 0;
        for (int ch = 0; ch < CH; ch++) begin
            m_duty[ch]   = 0;
            m_shadow[ch] = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock. Push the model's prediction first, then update the
    // model with the inputs that the DUT sees at this edge.
    task automatic step(input string tag);
        exp_t e;
        int   c;
        c = model_cnt();
        for (int ch = 0; ch < CH; ch++) begin
            e.pwm[ch] = enable && (c < m_duty[ch]);
        end
        e.ps = enable && (m_k == 0);
        sb.push_back(e);

        if (!enable || (m_k == model_len() - 1)) begin
            m_k    = 0;
            m_p    = int'(period_val);
            m_mode = int'(center_mode);
            for (int ch = 0; ch < CH; ch++) begin
                m_duty[ch] = duty_wr[ch] ? int'(duty_in[ch*WIDTH +: WIDTH]) : m_shadow[ch];
            end
        end else begin
            m_k++;
        end
        for (int ch = 0; ch < CH; ch++) begin
            if (duty_wr[ch]) m_shadow[ch] = int'(duty_in[ch*WIDTH +: WIDTH]);
        end

        @(posedge clk);
        #1;
        e        = sb.pop_front();
        last_pwm = pwm_out;
        last_ps  = period_start;
        check({tag, ":pwm"}, 32'(pwm_out), 32'(e.pwm));
        check({tag, ":ps"},  32'(period_start), 32'(e.ps));
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Step until the model's next counted position equals target. The loop is
    // bounded; running out of budget is reported as a failure.
    task automatic run_until_k(input int target, input string tag);
        int guard;
        guard = 0;
        while (m_k != target && guard < 600) begin
            step(tag);
            guard++;
        end
        check({tag, ":sync_timeout"}, 32'(guard < 600), 32'd1);
    endtask

    task automatic write_duty(input int ch, input int val, input string tag);
        duty_in[ch*WIDTH +: WIDTH] = WIDTH'(val);
        duty_wr[ch] = 1'b1;
        step(tag);
        duty_wr = '0;
    endtask

    logic [9:0] pat10;
    logic [7:0] pat8;

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        period_val  = '0;
        center_mode = 1'b0;
        duty_in     = '0;
        duty_wr     = '0;
        model_reset();

        // Reset state.
        @(posedge clk);
        #1;
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_ps",  32'(period_start), 32'd0);
        reset = 1'b0;

        // Edge mode, P=9, duties 3/0/10/255, all loaded while disabled.
        period_val = 8'd9;
        duty_in    = {8'd255, 8'd10, 8'd0, 8'd3};
        duty_wr    = 4'hf;
        step("load_edge");
        duty_wr    = '0;
        step("idle");
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step("edge_p9");
            pat10[9-i] = last_pwm[0];
            if (i == 0) check("edge_first_ps", 32'(last_ps), 32'd1);
        end
        check("edge_ch0_pattern", 32'(pat10), 32'b1110000000);
        run(20, "edge_p9");

        // Mid-period write: the current period keeps 3, the next period gets 7.
        run_until_k(4, "mid_sync");
        write_duty(0, 7, "mid_wr");
        run(20, "mid_after");

        // Write exactly in the boundary cycle: bypass into the next period.
        run_until_k(9, "bnd_sync");
        write_duty(0, 2, "bnd_wr");
        run(12, "bnd_after");

        // Switch to center P=4 in mid-period; the edge period completes first.
        run_until_k(3, "mode_sync");
        period_val  = 8'd4;
        center_mode = 1'b1;
        run(30, "center_p4");
        run_until_k(0, "ctr_sync");
        for (int i = 0; i < 8; i++) begin
            step("center_pat");
            pat8[7-i] = last_pwm[0];
            if (i == 0) check("center_first_ps", 32'(last_ps), 32'd1);
        end
        check("center_ch0_pattern", 32'(pat8), 32'b11000011);

        // Drop enable for 3 cycles and write a shadow while disabled.
        run_until_k(3, "dis_sync");
        enable = 1'b0;
        step("disabled");
        write_duty(1, 6, "dis_wr");
        step("disabled");
        enable = 1'b1;
        step("reenable");
        check("reenable_ps", 32'(last_ps), 32'd1);
        run(20, "reenable");

        // Center P=1 (sequence 0,0) and P=0 (every cycle a boundary).
        period_val = 8'd1;
        run(12, "center_p1");
        period_val = 8'd0;
        run(8, "center_p0");

        // Full-range period in both modes.
        duty_in = {8'd255, 8'd254, 8'd128, 8'd1};
        duty_wr = 4'hf;
        period_val  = 8'd255;
        center_mode = 1'b0;
        step("max_wr");
        duty_wr = '0;
        run(520, "edge_p255");
        center_mode = 1'b1;
        run(1030, "center_p255");

        // Reset in mid-period with d0=5.
        center_mode = 1'b0;
        period_val  = 8'd9;
        write_duty(0, 5, "pre_rst_wr");
        run(12, "pre_rst");
        run_until_k(2, "rst_sync");
        reset = 1'b1;
        #1;
        check("midrst_pwm", 32'(pwm_out), 32'd0);
        check("midrst_ps",  32'(period_start), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(20, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
